// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for the 4-bit up/down counter datapath.
// Drives q between captured bounds for a programmed number of sweeps; mode is the counter M input.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; q holds its last value
// UP    | counting toward hi_r
// DOWN  | counting toward lo_r; reaching lo_r ends one sweep
// DONE  | single-cycle completion state, done pulse visible here
module updown_sweep_ctrl #(
    parameter int WIDTH    = 4,
    parameter int NSWEEP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [NSWEEP_W-1:0] cycles,
    output logic [WIDTH-1:0]    q,
    output logic                mode,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    lo_r, hi_r, lo_nxt, hi_nxt;
    logic [NSWEEP_W-1:0] cyc_r, cyc_nxt;
    logic [NSWEEP_W-1:0] sweep, sweep_nxt, sweep_inc;
    logic [WIDTH-1:0]    q_nxt, q_inc, q_dec;
    logic                mode_nxt, busy_nxt, done_nxt, err_nxt;
    logic                last_sweep;

    assign q_inc      = q + WIDTH'(1);
    assign q_dec      = q - WIDTH'(1);
    assign sweep_inc  = sweep + NSWEEP_W'(1);
    assign last_sweep = (cyc_r != '0) && (sweep_inc == cyc_r);

    // mode is the direction of the step the counter takes at the next edge,
    // so it flips on the cycle a turnaround value is shown, not one cycle later.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        mode_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        lo_nxt    = lo_r;
        hi_nxt    = hi_r;
        cyc_nxt   = cyc_r;
        sweep_nxt = sweep;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        lo_nxt    = lo;
                        hi_nxt    = hi;
                        cyc_nxt   = cycles;
                        sweep_nxt = '0;
                        q_nxt     = lo;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_UP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (q != hi_r) begin
                    q_nxt    = q_inc;
                    mode_nxt = (q_inc == hi_r);
                    busy_nxt = 1'b1;
                end else begin
                    q_nxt     = q_dec;
                    mode_nxt  = !((q_dec == lo_r) && !last_sweep);
                    busy_nxt  = 1'b1;
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (q != lo_r) begin
                    q_nxt    = q_dec;
                    mode_nxt = !((q_dec == lo_r) && !last_sweep);
                    busy_nxt = 1'b1;
                end else begin
                    sweep_nxt = sweep_inc;
                    if (last_sweep) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        q_nxt     = q_inc;
                        mode_nxt  = (q_inc == hi_r);
                        busy_nxt  = 1'b1;
                        state_nxt = ST_UP;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q     <= '0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            lo_r  <= '0;
            hi_r  <= '0;
            cyc_r <= '0;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            mode  <= mode_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            lo_r  <= lo_nxt;
            hi_r  <= hi_nxt;
            cyc_r <= cyc_nxt;
            sweep <= sweep_nxt;
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: vector table, directed corner sequences and random traffic,
// all checked each cycle against an edge-index arithmetic model of the triangle sweep.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [3:0] cycles = '0;
    logic [3:0] q;
    logic       mode, busy, done, err;

    updown_sweep_ctrl #(.WIDTH(4), .NSWEEP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .lo(lo), .hi(hi), .cycles(cycles),
        .q(q), .mode(mode), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: phase 0 idle, 1 running, 2 done; k = edges since the accepting edge
    int m_phase, m_k, m_lo, m_hi, m_n;
    int m_q, m_mode, m_busy, m_done, m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_lo = 0; m_hi = 0; m_n = 0;
        m_q = 0; m_mode = 0; m_busy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        int d, p, ph;
        m_err  = 0;
        m_done = 0;
        case (m_phase)
            0: begin
                m_mode = 0;
                m_busy = 0;
                if (start) begin
                    if (int'(lo) < int'(hi)) begin
                        m_lo = int'(lo); m_hi = int'(hi); m_n = int'(cycles);
                        m_k = 0; m_q = m_lo; m_busy = 1; m_phase = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            1: begin
                if (stop) begin
                    m_phase = 0; m_busy = 0; m_mode = 0;
                end else begin
                    m_k++;
                    d = m_hi - m_lo;
                    p = 2 * d;
                    if (m_n != 0 && m_k == m_n * p + 1) begin
                        m_phase = 2; m_done = 1; m_busy = 0; m_mode = 0; m_q = m_lo;
                    end else begin
                        ph     = m_k % p;
                        m_q    = (ph <= d) ? m_lo + ph : m_hi - (ph - d);
                        m_mode = (m_n != 0 && m_k == m_n * p) ? 1 : ((ph >= d) ? 1 : 0);
                        m_busy = 1;
                    end
                end
            end
            default: begin
                m_phase = 0; m_busy = 0; m_mode = 0;
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        chk("q", int'(q), m_q);
        chk("mode", int'(mode), m_mode);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
        chk("err", int'(err), m_err);
    endtask

    typedef struct {
        int lo;
        int hi;
        int n;
        int exp_edge;   // edge index that enters DONE; -1 means rejected with err
    } vec_t;

    vec_t vecs[8];
    int   sq[8] = '{2, 3, 4, 5, 4, 3, 2, 2};
    int   sm[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int   got, dcount;

    initial begin
        vecs[0] = '{2, 5, 1, 7};
        vecs[1] = '{0, 15, 2, 61};
        vecs[2] = '{3, 4, 3, 7};
        vecs[3] = '{0, 1, 1, 3};
        vecs[4] = '{14, 15, 2, 5};
        vecs[5] = '{5, 5, 1, -1};
        vecs[6] = '{9, 3, 1, -1};
        vecs[7] = '{1, 9, 1, 17};

        model_reset();
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        #11 rst_n = 1'b1;
        cyc();

        // vector table, with inputs scrambled during each run to prove capture
        for (int i = 0; i < 8; i++) begin
            lo = 4'(vecs[i].lo); hi = 4'(vecs[i].hi); cycles = 4'(vecs[i].n);
            start = 1'b1;
            cyc();
            start = 1'b0;
            if (vecs[i].exp_edge < 0) begin
                chk("rej_err", int'(err), 1);
                chk("rej_busy", int'(busy), 0);
                cyc();
                chk("rej_err_clear", int'(err), 0);
            end else begin
                got = -1;
                for (int e = 1; e <= 100 && got < 0; e++) begin
                    lo = 4'($urandom); hi = 4'($urandom); cycles = 4'($urandom);
                    cyc();
                    if (done) got = e;
                end
                chk("done_edge", got, vecs[i].exp_edge);
                cyc();
            end
        end

        // single sweep, literal expected sequence
        lo = 4'd2; hi = 4'd5; cycles = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ss_q0", int'(q), sq[0]);
        chk("ss_m0", int'(mode), sm[0]);
        for (int e = 1; e < 8; e++) begin
            cyc();
            chk("ss_q", int'(q), sq[e]);
            chk("ss_mode", int'(mode), sm[e]);
        end
        chk("ss_done", int'(done), 1);
        chk("ss_busy", int'(busy), 0);
        cyc();
        chk("ss_done_clear", int'(done), 0);

        // hi changed mid-run, start while busy
        lo = 4'd2; hi = 4'd5; cycles = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0; hi = 4'd12;
        repeat (3) cyc();
        chk("cap_turn", int'(q), 5);
        cyc();
        chk("cap_after", int'(q), 4);
        start = 1'b1; lo = 4'd0; hi = 4'd9;
        cyc();
        start = 1'b0;
        chk("busy_start_q", int'(q), 3);
        chk("busy_start_busy", int'(busy), 1);
        repeat (2) cyc();
        chk("busy_done", int'(done), 1);
        cyc();

        // start and stop together in IDLE, then stop on the edge that would enter DONE
        lo = 4'd2; hi = 4'd5; cycles = 4'd1; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_start_busy", int'(busy), 1);
        chk("ss_start_q", int'(q), 2);
        repeat (6) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_final_done", int'(done), 0);
        chk("stop_final_busy", int'(busy), 0);
        chk("stop_final_q", int'(q), 2);
        cyc();
        chk("stop_final_done2", int'(done), 0);

        // continuous run, then stop while descending through 9
        lo = 4'd0; hi = 4'd15; cycles = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        dcount = 0;
        for (int e = 1; e <= 201; e++) begin
            cyc();
            if (done) dcount++;
        end
        chk("cont_no_done", dcount, 0);
        chk("cont_q9", int'(q), 9);
        chk("cont_down", int'(mode), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("cont_stop_q", int'(q), 9);
        chk("cont_stop_busy", int'(busy), 0);
        cyc();
        chk("cont_hold_q", int'(q), 9);

        // asynchronous reset in the middle of a run
        lo = 4'd0; hi = 4'd15; cycles = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (7) cyc();
        chk("pre_rst_q", int'(q), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_mode", int'(mode), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        model_reset();
        #3 rst_n = 1'b1;
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 5) == 0);
            stop   = ($urandom_range(0, 24) == 0);
            lo     = 4'($urandom);
            hi     = 4'($urandom);
            cycles = 4'($urandom_range(0, 3));
            cyc();
        end
        start = 1'b0; stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
